// File: rtl/pipe_hazard_ctrl_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
// Holds the FSM state encoding, the hazard-cause enum (debug visibility)
// and the mapping from a resolved cause to the per-stage stall/flush set.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    LU_WAIT = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    DMISS = 3'd1,
    LU    = 3'd2,
    TX    = 3'd3,
    IMISS = 3'd4
  } cause_e;

  // One bit per pipeline-register control; field order matches the port list.
  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
    logic idex_flush;
    logic ifid_flush;
  } ctl_t;

  function automatic ctl_t cause_ctl(input cause_e c);
    ctl_t r;
    r = '0;
    case (c)
      // Everything holds; no bubble, the MEM access must complete in place.
      DMISS: begin
        r.pc = 1'b1; r.ifid = 1'b1; r.idex = 1'b1; r.exmem = 1'b1; r.memwb = 1'b1;
      end
      // Hold the consumer in ID and slip a bubble into EX behind the load.
      LU: begin
        r.pc = 1'b1; r.ifid = 1'b1; r.idex_flush = 1'b1;
      end
      // Front end holds; the MEM write and older instructions drain.
      TX: begin
        r.pc = 1'b1; r.ifid = 1'b1; r.idex = 1'b1;
      end
      // Fetch has nothing valid: hold PC and feed a bubble into ID.
      IMISS: begin
        r.pc = 1'b1; r.ifid_flush = 1'b1;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// lu_detect: load-use comparator across NUM_SRC ID source operands.
// Ports: ld_ex/st_id qualify, dst_ex vs packed src_id/src_vld -> hit.
// Purely combinational, zero latency, no backpressure of its own.
module lu_detect #(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                      ld_ex,
  input  logic                      st_id,
  input  logic [REG_AW-1:0]         dst_ex,
  input  logic [NUM_SRC*REG_AW-1:0] src_id,
  input  logic [NUM_SRC-1:0]        src_vld,
  output logic                      hit
);

  logic match;
  logic dst_ok;

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_vld[i] && (src_id[i*REG_AW +: REG_AW] == dst_ex)) begin
        match = 1'b1;
      end
    end
  end

  // A hardwired-zero destination never produces a value worth waiting for.
  assign dst_ok = !(ZERO_REG && (dst_ex == '0));

  // Store data in ID is forwarded later, so a store consumer is never a hazard.
  assign hit = ld_ex & ~st_id & match & dst_ok;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage stall/flush generation for the 5-stage core
// (DMISS > load-use > SPART TX full > IMISS), plus load-use bubble FSM,
// miss watchdog with sticky timeout, and saturating stall-cycle counter.
// Ports: cache/SPART status and ID/EX/MEM decode in; five stalls, two flushes,
// timeout and stall_cnt out. Stalls/flushes are same-cycle combinational;
// counters/timeout update on the next edge. Backpressure is this block's output.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter int TMO_CYC  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_op,
  input  logic                      d_hit,
  input  logic                      i_hit,
  input  logic                      ld_ex,
  input  logic                      st_id,
  input  logic [REG_AW-1:0]         dst_ex,
  input  logic [NUM_SRC*REG_AW-1:0] src_id,
  input  logic [NUM_SRC-1:0]        src_vld,
  input  logic                      send,
  input  logic                      tx_full,
  input  logic                      tmo_clr,
  output logic                      pc_stall,
  output logic                      ifid_stall,
  output logic                      idex_stall,
  output logic                      exmem_stall,
  output logic                      memwb_stall,
  output logic                      idex_flush,
  output logic                      ifid_flush,
  output logic                      timeout,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int                WD_W   = $clog2(TMO_CYC + 1);
  localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TMO_CYC - 1);
  localparam logic [3:0]        BUB_LD = 4'(LOAD_LAT - 1);

  state_e          state, state_nxt;
  logic [3:0]      bub_cnt, bub_cnt_nxt;
  cause_e          cause;
  ctl_t            ctl;
  logic            lu_hit;
  logic            dmiss;
  logic            is_miss;
  logic [WD_W-1:0] wd_cnt;
  logic            tmo_set;

  lu_detect #(
    .REG_AW   (REG_AW),
    .NUM_SRC  (NUM_SRC),
    .ZERO_REG (ZERO_REG)
  ) u_lu_detect (
    .ld_ex   (ld_ex),
    .st_id   (st_id),
    .dst_ex  (dst_ex),
    .src_id  (src_id),
    .src_vld (src_vld),
    .hit     (lu_hit)
  );

  assign dmiss = mem_op & ~d_hit;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      bub_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_cnt_nxt;
    end
  end

  // Next state. A data miss freezes the bubble sequence; a fresh detect
  // (re)loads the remaining bubble count, LU_WAIT counts down to 1 then exits.
  always_comb begin
    state_nxt   = state;
    bub_cnt_nxt = bub_cnt;
    if (!dmiss) begin
      if (lu_hit) begin
        if (LOAD_LAT > 1) begin
          state_nxt   = LU_WAIT;
          bub_cnt_nxt = BUB_LD;
        end
      end else if (state == LU_WAIT) begin
        if (bub_cnt <= 4'd1) begin
          state_nxt   = RUN;
          bub_cnt_nxt = '0;
        end else begin
          bub_cnt_nxt = bub_cnt - 4'd1;
        end
      end
    end
  end

  // Outputs: resolve the winning cause, then expand it to stage controls.
  always_comb begin
    cause = NONE;
    if (dmiss)                          cause = DMISS;
    else if (lu_hit || state == LU_WAIT) cause = LU;
    else if (send && tx_full)           cause = TX;
    else if (!i_hit)                    cause = IMISS;
    ctl = cause_ctl(cause);
  end

  assign pc_stall    = ctl.pc;
  assign ifid_stall  = ctl.ifid;
  assign idex_stall  = ctl.idex;
  assign exmem_stall = ctl.exmem;
  assign memwb_stall = ctl.memwb;
  assign idex_flush  = ctl.idex_flush;
  assign ifid_flush  = ctl.ifid_flush;

  // Watchdog counts consecutive cycles whose resolved cause is a miss and
  // parks at its terminal value so a long miss keeps re-asserting the set.
  assign is_miss = (cause == DMISS) || (cause == IMISS);
  assign tmo_set = is_miss && (wd_cnt == WD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (!is_miss)              wd_cnt <= '0;
      else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
      // Set beats clear so a timeout landing on the clear cycle is not lost.
      if (tmo_set)      timeout <= 1'b1;
      else if (tmo_clr) timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (ctl.pc && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench driving two differently parameterised
// controllers from the same stimulus. Instance a: LOAD_LAT=3, ZERO_REG=1,
// TMO_CYC=8, CNT_W=3. Instance b: LOAD_LAT=1, ZERO_REG=0, defaults otherwise.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_op, d_hit, i_hit, ld_ex, st_id, send, tx_full, tmo_clr;
  logic [3:0] dst_ex;
  logic [7:0] src_id;
  logic [1:0] src_vld;

  logic pc_a, ifid_a, idex_a, exmem_a, memwb_a, idexf_a, ifidf_a, timeout_a;
  logic pc_b, ifid_b, idex_b, exmem_b, memwb_b, idexf_b, ifidf_b, timeout_b;
  logic [2:0]  stall_cnt_a;
  logic [15:0] stall_cnt_b;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW(4), .NUM_SRC(2), .LOAD_LAT(3), .ZERO_REG(1'b1), .TMO_CYC(8), .CNT_W(3)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .mem_op(mem_op), .d_hit(d_hit), .i_hit(i_hit),
    .ld_ex(ld_ex), .st_id(st_id), .dst_ex(dst_ex), .src_id(src_id), .src_vld(src_vld),
    .send(send), .tx_full(tx_full), .tmo_clr(tmo_clr),
    .pc_stall(pc_a), .ifid_stall(ifid_a), .idex_stall(idex_a), .exmem_stall(exmem_a),
    .memwb_stall(memwb_a), .idex_flush(idexf_a), .ifid_flush(ifidf_a),
    .timeout(timeout_a), .stall_cnt(stall_cnt_a)
  );

  pipe_hazard_ctrl #(
    .REG_AW(4), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG(1'b0), .TMO_CYC(1024), .CNT_W(16)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .mem_op(mem_op), .d_hit(d_hit), .i_hit(i_hit),
    .ld_ex(ld_ex), .st_id(st_id), .dst_ex(dst_ex), .src_id(src_id), .src_vld(src_vld),
    .send(send), .tx_full(tx_full), .tmo_clr(tmo_clr),
    .pc_stall(pc_b), .ifid_stall(ifid_b), .idex_stall(idex_b), .exmem_stall(exmem_b),
    .memwb_stall(memwb_b), .idex_flush(idexf_b), .ifid_flush(ifidf_b),
    .timeout(timeout_b), .stall_cnt(stall_cnt_b)
  );

  // {pc, ifid, idex, exmem, memwb, idex_flush, ifid_flush}
  localparam logic [6:0] O_NONE  = 7'b000_0000;
  localparam logic [6:0] O_DMISS = 7'b111_1100;
  localparam logic [6:0] O_LU    = 7'b110_0010;
  localparam logic [6:0] O_TX    = 7'b111_0000;
  localparam logic [6:0] O_IMISS = 7'b100_0001;

  logic [6:0] oa, ob;
  assign oa = {pc_a, ifid_a, idex_a, exmem_a, memwb_a, idexf_a, ifidf_a};
  assign ob = {pc_b, ifid_b, idex_b, exmem_b, memwb_b, idexf_b, ifidf_b};

  typedef struct packed {
    logic [6:0] a;
    logic [6:0] b;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [6:0] ea, input logic [6:0] eb);
    exp_t e;
    e.a = ea;
    e.b = eb;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_chk();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, "_a"}, 32'(oa), 32'(e.a));
    chk({t, "_b"}, 32'(ob), 32'(e.b));
  endtask

  // Called just after a negedge with inputs already driven; samples 1ns later
  // and returns at the following negedge (one full clock edge consumed).
  task automatic step(input string tag, input logic [6:0] ea, input logic [6:0] eb);
    push(tag, ea, eb);
    #1;
    pop_chk();
    @(negedge clk);
  endtask

  task automatic idle();
    mem_op = 1'b0; d_hit = 1'b1; i_hit = 1'b1; ld_ex = 1'b0; st_id = 1'b0;
    dst_ex = '0; src_id = '0; src_vld = '0; send = 1'b0; tx_full = 1'b0; tmo_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_cnt_a", 32'(stall_cnt_a), 32'd0);
    chk("rst_cnt_b", 32'(stall_cnt_b), 32'd0);
    chk("rst_tmo_a", 32'(timeout_a), 32'd0);
    step("reset", O_NONE, O_NONE);
    rst_n = 1'b1;

    // Data miss masks a pending load-use match for three cycles.
    mem_op = 1'b1; d_hit = 1'b0;
    ld_ex = 1'b1; dst_ex = 4'd5; src_id = {4'd5, 4'd0}; src_vld = 2'b10;
    for (int i = 0; i < 3; i++) step("dmiss_lu", O_DMISS, O_DMISS);
    mem_op = 1'b0; d_hit = 1'b1;
    step("lu_resume", O_LU, O_LU);
    idle();
    step("lu_wait1", O_LU, O_NONE);
    step("lu_wait2", O_LU, O_NONE);
    step("lu_done", O_NONE, O_NONE);
    chk("cnt_a_dm", 32'(stall_cnt_a), 32'd6);
    chk("cnt_b_dm", 32'(stall_cnt_b), 32'd4);

    // Single-cycle detect on source port 1: LOAD_LAT bubbles each.
    ld_ex = 1'b1; dst_ex = 4'd5; src_id = {4'd5, 4'd0}; src_vld = 2'b10;
    step("lu_pulse", O_LU, O_LU);
    idle();
    step("lu_p_w1", O_LU, O_NONE);
    step("lu_p_w2", O_LU, O_NONE);
    step("lu_p_end", O_NONE, O_NONE);
    chk("cnt_a_sat", 32'(stall_cnt_a), 32'd7);
    chk("cnt_b_lu", 32'(stall_cnt_b), 32'd5);

    ld_ex = 1'b1; dst_ex = 4'd5; src_id = {4'd5, 4'd5}; src_vld = 2'b00;
    step("lu_novld", O_NONE, O_NONE);
    src_vld = 2'b11; st_id = 1'b1;
    step("lu_store", O_NONE, O_NONE);

    // Second detect (port 0) during LU_WAIT reloads the bubble count.
    st_id = 1'b0; src_id = {4'd5, 4'd0}; src_vld = 2'b10;
    step("reload1", O_LU, O_LU);
    src_id = {4'd0, 4'd5}; src_vld = 2'b01;
    step("reload2", O_LU, O_LU);
    idle();
    step("reload3", O_LU, O_NONE);
    step("reload4", O_LU, O_NONE);
    step("reload5", O_NONE, O_NONE);

    // Destination register 0: suppressed only when ZERO_REG is set.
    ld_ex = 1'b1; dst_ex = 4'd0; src_id = 8'h00; src_vld = 2'b01;
    step("zero_reg", O_NONE, O_LU);
    idle();
    step("zero_after", O_NONE, O_NONE);
    chk("cnt_b_zero", 32'(stall_cnt_b), 32'd8);

    // SPART backpressure.
    send = 1'b1; tx_full = 1'b1;
    step("tx1", O_TX, O_TX);
    step("tx2", O_TX, O_TX);
    idle();
    step("tx_end", O_NONE, O_NONE);
    chk("cnt_b_tx", 32'(stall_cnt_b), 32'd10);
    send = 1'b1; tx_full = 1'b0;
    step("tx_notfull", O_NONE, O_NONE);

    // Fetch miss and priority ordering.
    idle(); i_hit = 1'b0;
    step("imiss", O_IMISS, O_IMISS);
    send = 1'b1; tx_full = 1'b1;
    step("tx_over_imiss", O_TX, O_TX);
    ld_ex = 1'b1; dst_ex = 4'd3; src_id = {4'd3, 4'd0}; src_vld = 2'b10;
    step("lu_over_tx", O_LU, O_LU);
    idle();
    step("lu_tx_w1", O_LU, O_NONE);
    step("lu_tx_w2", O_LU, O_NONE);
    step("lu_tx_end", O_NONE, O_NONE);
    chk("cnt_b_prio", 32'(stall_cnt_b), 32'd13);

    // Watchdog: timeout set after the 8th consecutive miss cycle.
    mem_op = 1'b1; d_hit = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step("tmo_miss", O_DMISS, O_DMISS);
      chk($sformatf("tmo_a_%0d", i), 32'(timeout_a), (i >= 8) ? 32'd1 : 32'd0);
      chk($sformatf("tmo_b_%0d", i), 32'(timeout_b), 32'd0);
    end
    idle();
    step("tmo_hold", O_NONE, O_NONE);
    chk("tmo_sticky", 32'(timeout_a), 32'd1);
    tmo_clr = 1'b1;
    step("tmo_clr", O_NONE, O_NONE);
    chk("tmo_cleared", 32'(timeout_a), 32'd0);

    // Set and clear in the same cycle: set wins.
    tmo_clr = 1'b0; mem_op = 1'b1; d_hit = 1'b0;
    for (int i = 0; i < 7; i++) step("tmo_re", O_DMISS, O_DMISS);
    chk("tmo_pre_set", 32'(timeout_a), 32'd0);
    tmo_clr = 1'b1;
    step("tmo_set_clr", O_DMISS, O_DMISS);
    chk("tmo_set_wins", 32'(timeout_a), 32'd1);
    idle(); tmo_clr = 1'b1;
    step("tmo_clr2", O_NONE, O_NONE);
    chk("tmo_cleared2", 32'(timeout_a), 32'd0);
    tmo_clr = 1'b0;

    // Asynchronous reset in the middle of LU_WAIT.
    ld_ex = 1'b1; dst_ex = 4'd5; src_id = {4'd5, 4'd0}; src_vld = 2'b10;
    step("pre_rst", O_LU, O_LU);
    idle();
    push("rst_lu_wait", O_LU, O_NONE);
    #1;
    pop_chk();
    #1;
    rst_n = 1'b0;
    push("rst_async", O_NONE, O_NONE);
    #1;
    pop_chk();
    chk("rst_async_cnt_a", 32'(stall_cnt_a), 32'd0);
    chk("rst_async_cnt_b", 32'(stall_cnt_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst1", O_NONE, O_NONE);
    step("post_rst2", O_NONE, O_NONE);
    chk("post_rst_cnt_a", 32'(stall_cnt_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline hazard and stall controller for the 5-stage core. It generates per-stage stall and flush controls for four hazard classes: data-cache miss, instruction-fetch miss, load-use (with a configurable bubble count), and SPART transmit backpressure. It adds registered state for multi-cycle load-use bubbles, a miss watchdog and a saturating stall-cycle counter. It sits beside the pipeline registers, fed from the ID/EX/MEM stage decode and the cache/SPART status.

Parameters:
REG_AW, 4, register address width
NUM_SRC, 2, source-operand ports checked in ID
LOAD_LAT, 1, bubbles inserted per load-use hazard (1..15)
ZERO_REG, 1, when 1 a destination of address 0 never raises load-use
TMO_CYC, 1024, consecutive miss-stall cycles before timeout
CNT_W, 16, stall counter width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
mem_op  in  1  MEM-stage load/store valid
d_hit  in  1  data-cache hit
i_hit  in  1  instruction fetch valid/hit
ld_ex  in  1  EX-stage instruction is a load
st_id  in  1  ID-stage instruction is a store (store data forwarded, no hazard)
dst_ex  in  REG_AW  EX load destination
src_id  in  NUM_SRC*REG_AW  ID source addresses, packed, port 0 in LSBs
src_vld  in  NUM_SRC  per-source valid
send  in  1  MEM-stage SPART write
tx_full  in  1  SPART TX queue full
tmo_clr  in  1  clears sticky timeout
pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall  out  1 each  hold stage register
idex_flush  out  1  load ID/EX with bubble
ifid_flush  out  1  load IF/ID with bubble
timeout  out  1  sticky watchdog flag
stall_cnt  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Clock: clk; reset: rst_n, asynchronous and active-low. Reset: state=RUN, bubble counter=0, watchdog=0, timeout=0, stall_cnt=0. Stall/flush outputs are combinational from state and inputs; with inputs idle after reset, all are 0.
- Priority per cycle, highest first:
  - DMISS: mem_op & ~d_hit.
  - LU: load-use detect, or state=LU_WAIT.
  - TX: send & tx_full.
  - IMISS: ~i_hit.
  - RUN.
- DMISS: all five stalls=1, both flushes=0. Bubble counter frozen.
- Load-use detect: ld_ex & ~st_id & any i with src_vld[i] and src_id[i]==dst_ex. With ZERO_REG=1, a dst_ex of 0 suppresses detection.
  - Detect cycle: pc_stall=ifid_stall=idex_flush=1; all other stalls 0.
  - If LOAD_LAT>1, enter LU_WAIT with counter=LOAD_LAT-1.
  - Each LU_WAIT cycle not overridden by DMISS: same outputs as detect, counter decrements. Return to RUN when counter reaches 1.
  - A new detect while in LU_WAIT reloads the counter.
- TX: pc_stall=ifid_stall=idex_stall=1; EX/MEM and MEM/WB advance. No flush.
- IMISS: pc_stall=1, ifid_flush=1, so a bubble enters ID. Downstream stages advance.
- Watchdog: increments on each DMISS or IMISS cycle and resets to 0 on any other cycle. When it reaches TMO_CYC-1, timeout is set on the next edge. Timeout stays set until tmo_clr; if tmo_clr and a set event occur in the same cycle, set wins. Timeout is informational and does not alter the stall outputs.
- stall_cnt increments on each clock edge where pc_stall=1 and saturates at all-ones.
- Reset mid-stall: returns to RUN immediately; the pending bubble count is discarded.
- Latency: stall/flush respond in the same cycle as their inputs. Counters and timeout update on the next edge.

Decomposition:
- Shared package hazard_pkg: state encoding (RUN, LU_WAIT) and a hazard-cause enum (NONE, DMISS, LU, TX, IMISS) used for debug.
- Natural sub-module: lu_detect, a parametrised NUM_SRC comparator producing the load-use hit.
- Watchdog and stall counter stay inline.

Test Plan:
- mem_op=1, d_hit=0 for 3 cycles while a load-use match is present -> all five stalls=1 and idex_flush=0 for 3 cycles; load-use handling resumes on cycle 4.
- ld_ex=1, dst_ex=5, src_id[1]=5, src_vld=2'b10, LOAD_LAT=3 -> pc_stall/ifid_stall/idex_flush=1 for exactly 3 cycles, then 0. Repeat with src_vld=0 -> no stall.
- dst_ex=0 matching src 0, ZERO_REG=1 -> no stall; with ZERO_REG=0 -> 1-cycle bubble.
- send=1, tx_full=1 for 2 cycles -> pc/ifid/idex stalls=1 and exmem/memwb=0 for 2 cycles; stall_cnt increases by 2.
- TMO_CYC=8, d_hit held 0 for 10 cycles -> timeout rises after 8 miss cycles and stays set until tmo_clr pulses. With CNT_W=3 and 10 stalls, stall_cnt=7.
- rst_n asserted asynchronously mid-LU_WAIT -> outputs and counters 0 before the next clk edge; no residual bubble after release.
